uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter byte stream among NumReq requesters.
- Requesters include CPU console, debug/trace dumper and status reporter.
- Round-robin arbitration at packet granularity: once granted, a requester owns the transmitter until it marks the last byte, hits the burst limit, or stalls past the idle timeout.
- Sits between requester FIFOs and the uart top-level data_i / data_valid_i / data_in_ready_o handshake.

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int unsigned BeatW   = 8;
  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxIdxW = 3;

  // One-hot winner: first set bit of req at or after (last+1) mod n, wrapping.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0]  req,
                                                input logic [MaxIdxW-1:0] last,
                                                input int unsigned        n);
    logic [MaxReq-1:0]  pick;
    logic [MaxIdxW-1:0] idx;
    pick = '0;
    idx  = '0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      if (i <= n) begin
        idx = MaxIdxW'((32'(last) + i) % n);
        if ((pick == '0) && req[idx]) pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: request vector and last owner in,
// one-hot winner and its index out.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_last,
  output logic [NumReq-1:0] o_grant_c,
  output logic [IdxW-1:0]   o_idx_c
);

  logic [MaxReq-1:0] w_pick;
  logic              w_pick_unused;

  always_comb begin
    w_pick    = rr_pick(MaxReq'(i_req), MaxIdxW'(i_last), NumReq);
    o_grant_c = w_pick[NumReq-1:0];
    o_idx_c   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (w_pick[k]) o_idx_c = IdxW'(k);
    end
  end

  // Padding bits above NumReq are always zero.
  assign w_pick_unused = ^w_pick;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte stream among
// NumReq requesters, with burst-limit and idle-timeout forced release.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned MaxBurst    = 64,
  parameter int unsigned IdleTimeout = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NumReq*8-1:0]   req_data_i,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [NumReq-1:0]     grant_o,
  output logic                  timeout_o
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned IdleW = $clog2(IdleTimeout + 1);

  arb_state_t          r_state;
  logic [NumReq-1:0]   r_grant;
  logic [IdxW-1:0]     r_gidx;
  logic [IdxW-1:0]     r_last;
  logic [BeatW-1:0]    r_beat;
  logic [IdleW-1:0]    r_idle;

  logic [NumReq-1:0]   w_pick_grant;
  logic [IdxW-1:0]     w_pick_idx;
  logic [7:0]          w_data;
  logic                w_locked;
  logic                w_gvalid;
  logic                w_glast;
  logic                w_xfer;
  logic                w_burst_end;
  logic                w_idle_end;
  logic                w_release;

  uart_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .i_req     (req_valid_i),
    .i_last    (r_last),
    .o_grant_c (w_pick_grant),
    .o_idx_c   (w_pick_idx)
  );

  // One-hot OR mux; r_grant is zero outside LOCKED so the byte reads as 0.
  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (r_grant[k]) w_data = w_data | req_data_i[8*k +: 8];
    end
  end

  assign w_locked    = (r_state == ARB_LOCKED);
  assign w_gvalid    = w_locked & (|(r_grant & req_valid_i));
  assign w_glast     = |(r_grant & req_valid_i & req_last_i);
  assign w_xfer      = w_gvalid & tx_ready_i & ~reset_i;
  assign w_burst_end = (r_beat == BeatW'(MaxBurst - 1));
  assign w_idle_end  = w_locked & ~w_gvalid & (r_idle == IdleW'(IdleTimeout - 1));
  assign w_release   = (w_xfer & (w_glast | w_burst_end)) | w_idle_end;

  // Reset cycle must not accept a byte, so the handshake is gated by reset_i.
  assign tx_data_o   = w_data;
  assign tx_valid_o  = w_gvalid & ~reset_i;
  assign req_ready_o = r_grant & {NumReq{tx_ready_i & w_locked & ~reset_i}};
  assign timeout_o   = w_idle_end & ~reset_i;
  assign grant_o     = r_grant;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IdxW'(NumReq - 1);
      r_beat  <= '0;
      r_idle  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_beat <= '0;
          r_idle <= '0;
          if (|req_valid_i) begin
            r_state <= ARB_LOCKED;
            r_grant <= w_pick_grant;
            r_gidx  <= w_pick_idx;
          end
        end
        ARB_LOCKED: begin
          if (w_release) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= r_gidx;
            r_beat  <= '0;
            r_idle  <= '0;
          end else if (w_xfer) begin
            r_beat <= r_beat + 1'b1;
            r_idle <= '0;
          end else if (!w_gvalid && (r_idle != '1)) begin
            // Backpressure (valid high, ready low) holds the idle count.
            r_idle <= r_idle + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, a
// monitor checks every UART transfer against hand-ordered expected bytes.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } src_t;

  logic            clk;
  logic            reset_i;
  logic [NR*8-1:0] req_data_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR-1:0]   req_last_i;
  logic [NR-1:0]   req_ready_o;
  logic [7:0]      tx_data_o;
  logic            tx_valid_o;
  logic            tx_ready_i;
  logic [NR-1:0]   grant_o;
  logic            timeout_o;

  src_t          src_q [NR][$];
  logic [11:0]   exp_q [$];
  logic [NR-1:0] acc;
  logic [NR-1:0] hold;
  logic          rst_ctl;
  logic          rdy_ctl;
  int            n_checks;
  int            n_fail;
  int            n_to;

  uart_tx_arbiter #(
    .NumReq      (NR),
    .MaxBurst    (4),
    .IdleTimeout (8)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic drive();
    logic [NR*8-1:0] d;
    logic [NR-1:0]   v;
    logic [NR-1:0]   l;
    d = '0;
    v = '0;
    l = '0;
    for (int k = 0; k < NR; k++) begin
      if (!hold[k] && src_q[k].size() > 0) begin
        v[k]         = 1'b1;
        d[8*k +: 8]  = src_q[k][0].data;
        l[k]         = src_q[k][0].last;
      end
    end
    reset_i     = rst_ctl;
    tx_ready_i  = rdy_ctl;
    req_data_i  = d;
    req_valid_i = v;
    req_last_i  = l;
  endtask

  // Advance one cycle; returns at the negedge with new outputs settled.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc[k] && src_q[k].size() > 0) src_q[k].delete(0);
    end
    drive();
    @(negedge clk);
    acc = req_valid_i & req_ready_o;
  endtask

  task automatic push_src(input int k, input logic [7:0] d, input logic last);
    src_t s;
    s.data = d;
    s.last = last;
    src_q[k].push_back(s);
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    logic [3:0] g;
    g = 4'(1 << k);
    exp_q.push_back({g, d});
  endtask

  // Monitor: every accepted UART byte must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected actual=%0h required=none at %0t", {grant_o, tx_data_o}, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_byte", 32'({grant_o, tx_data_o}), 32'(e));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] gp [13];
    logic [3:0] want;
    n_checks = 0;
    n_fail   = 0;
    acc      = '0;
    hold     = '0;
    rst_ctl  = 1'b1;
    rdy_ctl  = 1'b1;
    drive();

    // Reset values
    tick();
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_txvalid", 32'(tx_valid_o), 0);
    chk("rst_txdata", 32'(tx_data_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    rst_ctl = 1'b0;
    tick();

    // Single requester, 3-byte packet
    push_src(1, 8'h41, 1'b0); push_exp(1, 8'h41);
    push_src(1, 8'h42, 1'b0); push_exp(1, 8'h42);
    push_src(1, 8'h43, 1'b1); push_exp(1, 8'h43);
    tick();
    chk("single_grant_pre", 32'(grant_o), 0);
    tick();
    chk("single_grant", 32'(grant_o), 32'h2);
    tick();
    tick();
    tick();
    chk("single_release", 32'(grant_o), 0);
    chk("single_drained", exp_q.size(), 0);
    tick();

    // Fairness from reset: two 2-byte packets per requester
    rst_ctl = 1'b1;
    tick();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NR; k++)
        for (int j = 0; j < 2; j++) begin
          push_src(k, 8'(k * 16 + p * 2 + j), (j == 1));
          push_exp(k, 8'(k * 16 + p * 2 + j));
        end
    rst_ctl = 1'b0;
    tick();
    for (int c = 0; c < 24; c++) begin
      want = (c % 3 == 0) ? 4'h0 : 4'(1 << ((c / 3) % 4));
      chk("fair_grant", 32'(grant_o), 32'(want));
      tick();
    end
    chk("fair_drained", exp_q.size(), 0);

    // Burst limit 4, 10 bytes with no last, then idle timeout
    gp = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4};
    for (int i = 0; i < 10; i++) begin
      push_src(2, 8'(8'h21 + i), 1'b0);
      push_exp(2, 8'(8'h21 + i));
    end
    tick();
    for (int c = 0; c < 13; c++) begin
      chk("burst_grant", 32'(grant_o), 32'(gp[c]));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk("burst_to_pulse", 32'(timeout_o), 32'(i == 7));
      chk("burst_to_grant", 32'(grant_o), 32'h4);
      tick();
    end
    chk("burst_to_release", 32'(grant_o), 0);
    chk("burst_drained", exp_q.size(), 0);

    // Backpressure does not time out; dropped valid does
    rdy_ctl = 1'b0;
    push_src(0, 8'h5A, 1'b1);
    push_exp(0, 8'h5A);
    tick();
    chk("bp_grant_pre", 32'(grant_o), 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("bp_grant", 32'(grant_o), 32'h1);
      chk("bp_hold", 32'({tx_valid_o, tx_data_o}), 32'h15A);
      chk("bp_no_timeout", 32'(timeout_o), 0);
      tick();
    end
    hold[0] = 1'b1;
    tick();
    n_to = 0;
    for (int i = 0; i < 8; i++) begin
      if (timeout_o === 1'b1) n_to++;
      chk("idle_to_grant", 32'(grant_o), 32'h1);
      tick();
    end
    chk("idle_to_count", n_to, 1);
    chk("idle_to_release", 32'(grant_o), 0);
    chk("idle_to_pulse_end", 32'(timeout_o), 0);
    hold[0] = 1'b0;
    rdy_ctl = 1'b1;
    tick();
    tick();
    chk("bp_regrant", 32'(grant_o), 32'h1);
    tick();
    chk("bp_done", 32'(grant_o), 0);
    chk("bp_drained", exp_q.size(), 0);

    // Reset mid-packet, then req0 beats req3
    push_src(3, 8'h31, 1'b0);
    push_src(3, 8'h32, 1'b0);
    push_src(3, 8'h33, 1'b0);
    push_src(3, 8'h34, 1'b1);
    push_exp(3, 8'h31);
    tick();
    tick();
    chk("rstmid_grant", 32'(grant_o), 32'h8);
    rst_ctl = 1'b1;
    tick();
    chk("rstmid_no_ready", 32'(req_ready_o), 0);
    chk("rstmid_no_valid", 32'(tx_valid_o), 0);
    push_src(0, 8'h01, 1'b0);
    push_src(0, 8'h02, 1'b1);
    push_exp(0, 8'h01);
    push_exp(0, 8'h02);
    push_exp(3, 8'h32);
    push_exp(3, 8'h33);
    push_exp(3, 8'h34);
    rst_ctl = 1'b0;
    tick();
    chk("rstmid_grant0", 32'(grant_o), 0);
    chk("rstmid_valid0", 32'(tx_valid_o), 0);
    chk("rstmid_data0", 32'(tx_data_o), 0);
    chk("rstmid_ready0", 32'(req_ready_o), 0);
    chk("rstmid_to0", 32'(timeout_o), 0);
    tick();
    chk("rstmid_req0_first", 32'(grant_o), 32'h1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("final_drained", exp_q.size(), 0);
    chk("final_src_empty",
        src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
